esp32_spi_cmd_decoder: RTL and testbench
========================================

ESP32_SPI_CMD_DECODER -- requirements
Module: esp32_spi_cmd_decoder

Interface
REQ-001 Parameter MEM_AW, default 16, memory write address width.
REQ-002 Parameter NREG, default 16, number of 8-bit control registers (power of two).
REQ-003 clk_sys  in  1  sole clock, 50 MHz system clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rx_data  in  8  received byte from the SPI slave.
REQ-006 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-007 busy  in  1  SPI frame active (CS asserted); a frame is one high period.
REQ-008 tx_data  out  8  response byte to the SPI slave.
REQ-009 tx_load  out  1  one-cycle strobe, tx_data valid.
REQ-010 regs  out  8*NREG  flat control-register bank; reg i occupies bits [8i+7:8i].
REQ-011 mem_we  out  1  one-cycle memory write strobe.
REQ-012 mem_addr  out  MEM_AW  memory write address.
REQ-013 mem_wdata  out  8  memory write data.
REQ-014 status_in  in  8  live status byte returned by CMD_STATUS.
REQ-015 err_cnt  out  8  count of unknown-opcode frames, saturating at 0xFF.

Function
REQ-016 Opcodes: CMD_STATUS=0x00, CMD_WR_REG=0x10, CMD_RD_REG=0x20, CMD_WR_MEM=0x30; all others are unknown.
REQ-017 States: S_IDLE, S_CMD, S_RADDR, S_WDATA, S_RDATA, S_MADDR_HI, S_MADDR_LO, S_MDATA, S_DISCARD.
REQ-018 S_IDLE -> S_CMD on the cycle busy is first sampled high; from every state, busy low returns to S_IDLE on the next cycle.
REQ-019 On busy low in the same cycle as rx_valid, the byte is dropped, with no write, tx_load or counter update.
REQ-020 In S_CMD, the first rx_valid decodes the opcode:
- WR_REG/RD_REG -> S_RADDR.
- WR_MEM -> S_MADDR_HI.
- STATUS -> S_DISCARD, with tx_load carrying status_in one cycle after rx_valid.
- Unknown -> S_DISCARD, err_cnt +1 (saturating).
REQ-021 S_RADDR: the byte's low log2(NREG) bits load the register pointer; the next state is S_WDATA for WR_REG and S_RDATA for RD_REG.
REQ-022 On entering S_RDATA, tx_load pulses one cycle after the address rx_valid, with tx_data = reg[ptr]; ptr then increments.
REQ-023 S_WDATA: each rx_valid writes reg[ptr] <= rx_data (visible on regs the next cycle), then ptr increments.
REQ-024 S_RDATA: each further rx_valid (dummy byte) produces tx_load one cycle later with tx_data = reg[ptr], then ptr increments.
REQ-025 ptr wraps modulo NREG.
REQ-026 S_MADDR_HI/S_MADDR_LO load the high and low address bytes (truncated to MEM_AW), then go to S_MDATA.
REQ-027 S_MDATA: each rx_valid gives mem_we=1, mem_addr=current address, mem_wdata=rx_data one cycle after rx_valid; the address then increments, wrapping at 2^MEM_AW.
REQ-028 S_DISCARD ignores all bytes until busy falls.
REQ-029 tx_load and mem_we are never asserted more than one cycle per rx_valid, and never in S_IDLE.
REQ-030 tx_data holds its last value between strobes.

Reset
REQ-031 While rst is high:
- state = S_IDLE.
- tx_data = 0x00, tx_load = 0.
- mem_we = 0, mem_addr = 0, mem_wdata = 0.
- All regs = 0x00, err_cnt = 0.
REQ-032 Reset asserted mid-frame abandons the frame; after rst falls with busy still high, the block re-enters S_CMD and treats the next byte as an opcode.

Structure
REQ-033 Shared package esp32_spi_pkg holds the opcode constants and the state enum typedef.
REQ-034 The register bank (write port, read mux, flat output) is one sub-module, spi_cmd_regfile; the FSM, pointers and memory port stay in the top module.

Verification
REQ-035 Frame [0x10,0x03,0xAA,0xBB] -> reg3=0xAA, reg4=0xBB; no tx_load.
REQ-036 After REQ-035, frame [0x20,0x03,0x00,0x00] -> tx_load 3 times, tx_data 0xAA, 0xBB, 0x00, each 1 cycle after its rx_valid.
REQ-037 Frame [0x30,0x12,0x34,0x01,0x02] -> mem_we twice: (0x1234,0x01), then (0x1235,0x02).
REQ-038 Frame [0x10,0x0F,0x11,0x22] -> reg15=0x11, reg0=0x22 (pointer wrap).
REQ-039 Frame [0x77,0x10,0x05,0x99]:
- err_cnt=1.
- No register change.
- Next frame [0x00,0x00] with status_in=0x5A -> tx_data=0x5A.
REQ-040 Mid-frame cases:
- busy drops after [0x30,0x00]; the next frame starts at S_CMD and produces no mem_we.
- rst pulsed mid WR_REG burst -> all regs=0.

Source files
------------

// File: rtl/esp32_spi_pkg.sv
// rtl/esp32_spi_pkg.sv - opcode constants and FSM state type for the SPI command decoder
package esp32_spi_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_WR_REG = 8'h10;
    localparam logic [7:0] CMD_RD_REG = 8'h20;
    localparam logic [7:0] CMD_WR_MEM = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_RADDR,
        S_WDATA,
        S_RDATA,
        S_MADDR_HI,
        S_MADDR_LO,
        S_MDATA,
        S_DISCARD
    } spi_state_e;

endpackage

// File: rtl/spi_cmd_regfile.sv
// rtl/spi_cmd_regfile.sv - 8-bit control register bank with one write port, one read port and flat output
module spi_cmd_regfile #(
    parameter int NREG = 16,
    parameter int PW   = 4
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [7:0]        wdata,
    input  logic [PW-1:0]     raddr,
    output logic [7:0]        rdata,
    output logic [8*NREG-1:0] regs
);

    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata = regs_q[raddr];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs[8*g +: 8] = regs_q[g];
    end

endmodule

// File: rtl/esp32_spi_cmd_decoder.sv
// rtl/esp32_spi_cmd_decoder.sv - SPI byte-stream command decoder driving a register bank and a memory write port
module esp32_spi_cmd_decoder
    import esp32_spi_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int NREG   = 16
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    output logic [8*NREG-1:0] regs,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        status_in,
    output logic [7:0]        err_cnt
);

    localparam int PW = (NREG > 1) ? $clog2(NREG) : 1;

    spi_state_e state_q, state_d;

    logic              is_rd_q, is_rd_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [MEM_AW-1:0] maddr_q, maddr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_load_q, tx_load_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic              reg_we;
    logic [PW-1:0]     reg_raddr;
    logic [7:0]        reg_rdata;

    // A byte arriving as CS releases belongs to no frame and is dropped.
    logic byte_ok;
    assign byte_ok = rx_valid & busy;

    spi_cmd_regfile #(
        .NREG (NREG),
        .PW   (PW)
    ) u_regfile (
        .clk_sys (clk_sys),
        .rst     (rst),
        .we      (reg_we),
        .waddr   (ptr_q),
        .wdata   (rx_data),
        .raddr   (reg_raddr),
        .rdata   (reg_rdata),
        .regs    (regs)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!busy) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_CMD;
                S_CMD: begin
                    if (byte_ok) begin
                        case (rx_data)
                            CMD_WR_REG, CMD_RD_REG: state_d = S_RADDR;
                            CMD_WR_MEM:             state_d = S_MADDR_HI;
                            default:                state_d = S_DISCARD;
                        endcase
                    end
                end
                S_RADDR: begin
                    if (byte_ok) begin
                        state_d = is_rd_q ? S_RDATA : S_WDATA;
                    end
                end
                S_MADDR_HI: if (byte_ok) state_d = S_MADDR_LO;
                S_MADDR_LO: if (byte_ok) state_d = S_MDATA;
                S_WDATA, S_RDATA, S_MDATA, S_DISCARD: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        is_rd_d     = is_rd_q;
        ptr_d       = ptr_q;
        addr_hi_d   = addr_hi_q;
        maddr_d     = maddr_q;
        err_cnt_d   = err_cnt_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_we      = 1'b0;
        reg_raddr   = ptr_q;
        if (byte_ok) begin
            case (state_q)
                S_CMD: begin
                    is_rd_d = (rx_data == CMD_RD_REG);
                    case (rx_data)
                        CMD_STATUS: begin
                            tx_load_d = 1'b1;
                            tx_data_d = status_in;
                        end
                        CMD_WR_REG, CMD_RD_REG, CMD_WR_MEM: ;
                        default: begin
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end
                    endcase
                end
                S_RADDR: begin
                    ptr_d = rx_data[PW-1:0];
                    // Reads respond to the address byte itself, so look up the new pointer directly.
                    if (is_rd_q) begin
                        reg_raddr = rx_data[PW-1:0];
                        tx_load_d = 1'b1;
                        tx_data_d = reg_rdata;
                        ptr_d     = rx_data[PW-1:0] + PW'(1);
                    end
                end
                S_WDATA: begin
                    reg_we = 1'b1;
                    ptr_d  = ptr_q + PW'(1);
                end
                S_RDATA: begin
                    tx_load_d = 1'b1;
                    tx_data_d = reg_rdata;
                    ptr_d     = ptr_q + PW'(1);
                end
                S_MADDR_HI: addr_hi_d = rx_data;
                S_MADDR_LO: maddr_d = MEM_AW'({addr_hi_q, rx_data});
                S_MDATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = maddr_q;
                    mem_wdata_d = rx_data;
                    maddr_d     = maddr_q + MEM_AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            is_rd_q     <= 1'b0;
            ptr_q       <= '0;
            addr_hi_q   <= 8'h00;
            maddr_q     <= '0;
            err_cnt_q   <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
        end else begin
            is_rd_q     <= is_rd_d;
            ptr_q       <= ptr_d;
            addr_hi_q   <= addr_hi_d;
            maddr_q     <= maddr_d;
            err_cnt_q   <= err_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_esp32_spi_cmd_decoder.sv
// tb/tb_esp32_spi_cmd_decoder.sv - directed self-checking bench for esp32_spi_cmd_decoder
module tb_esp32_spi_cmd_decoder;

    localparam int MEM_AW = 16;
    localparam int NREG   = 16;

    logic              clk_sys = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              busy;
    logic [7:0]        tx_data;
    logic              tx_load;
    logic [8*NREG-1:0] regs;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        status_in;
    logic [7:0]        err_cnt;

    esp32_spi_cmd_decoder #(
        .MEM_AW (MEM_AW),
        .NREG   (NREG)
    ) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .regs      (regs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .status_in (status_in),
        .err_cnt   (err_cnt)
    );

    always #10 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx_q [$];
    logic [23:0] mem_q [$];
    int          lat_bad = 0;
    logic        prev_rxv = 1'b0;

    // Strobes must land exactly one cycle after an accepted byte.
    always @(negedge clk_sys) begin
        if (tx_load) tx_q.push_back(tx_data);
        if (mem_we)  mem_q.push_back({mem_addr, mem_wdata});
        if ((tx_load || mem_we) && !prev_rxv) lat_bad <= lat_bad + 1;
        prev_rxv <= rx_valid & busy;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tx_at(input int i);
        return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
    endfunction

    function automatic logic [23:0] mem_at(input int i);
        return (i < mem_q.size()) ? mem_q[i] : 24'hxxxxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] bs [5];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3; bs[4] = b4;
        busy = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) send_byte(bs[i]);
        tick(1);
        busy = 1'b0;
        tick(3);
    endtask

    logic [127:0] exp_regs;
    int t0, m0;

    initial begin
        rst = 1'b1; busy = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; status_in = 8'h00;
        tick(3);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_tx_load", tx_load, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 16'h0000);
        check_eq("rst_mem_wdata", mem_wdata, 8'h00);
        check_eq("rst_regs", regs, 128'h0);
        check_eq("rst_err_cnt", err_cnt, 8'h00);
        rst = 1'b0;
        tick(2);

        t0 = tx_q.size();
        send_frame(4, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'h00);
        check_eq("wr_reg3", regs[8*3 +: 8], 8'hAA);
        check_eq("wr_reg4", regs[8*4 +: 8], 8'hBB);
        check_eq("wr_no_tx", tx_q.size() - t0, 0);

        t0 = tx_q.size();
        send_frame(4, 8'h20, 8'h03, 8'h00, 8'h00, 8'h00);
        check_eq("rd_count", tx_q.size() - t0, 3);
        check_eq("rd_0", tx_at(t0), 8'hAA);
        check_eq("rd_1", tx_at(t0 + 1), 8'hBB);
        check_eq("rd_2", tx_at(t0 + 2), 8'h00);

        m0 = mem_q.size();
        send_frame(5, 8'h30, 8'h12, 8'h34, 8'h01, 8'h02);
        check_eq("mem_count", mem_q.size() - m0, 2);
        check_eq("mem_0", mem_at(m0), 24'h123401);
        check_eq("mem_1", mem_at(m0 + 1), 24'h123502);

        send_frame(4, 8'h10, 8'h0F, 8'h11, 8'h22, 8'h00);
        check_eq("wrap_reg15", regs[8*15 +: 8], 8'h11);
        check_eq("wrap_reg0", regs[8*0 +: 8], 8'h22);

        exp_regs = 128'h0;
        exp_regs[8*3 +: 8]  = 8'hAA;
        exp_regs[8*4 +: 8]  = 8'hBB;
        exp_regs[8*15 +: 8] = 8'h11;
        exp_regs[8*0 +: 8]  = 8'h22;
        send_frame(4, 8'h77, 8'h10, 8'h05, 8'h99, 8'h00);
        check_eq("unk_err_cnt", err_cnt, 8'h01);
        check_eq("unk_regs", regs, exp_regs);

        status_in = 8'h5A;
        t0 = tx_q.size();
        send_frame(2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        status_in = 8'h00;
        check_eq("status_count", tx_q.size() - t0, 1);
        check_eq("status_val", tx_at(t0), 8'h5A);
        tick(5);
        check_eq("tx_data_hold", tx_data, 8'h5A);

        m0 = mem_q.size();
        busy = 1'b1;
        tick(2);
        send_byte(8'h30); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01);
        rx_data = 8'h02; rx_valid = 1'b1; busy = 1'b0;
        tick(1);
        rx_valid = 1'b0;
        tick(3);
        check_eq("drop_count", mem_q.size() - m0, 1);
        check_eq("drop_mem_0", mem_at(m0), 24'h001001);

        m0 = mem_q.size();
        busy = 1'b1;
        tick(2);
        send_byte(8'h30); send_byte(8'h00);
        busy = 1'b0;
        tick(2);
        send_frame(3, 8'h10, 8'h05, 8'h66, 8'h00, 8'h00);
        exp_regs[8*5 +: 8] = 8'h66;
        check_eq("abort_no_mem", mem_q.size() - m0, 0);
        check_eq("abort_regs", regs, exp_regs);
        check_eq("latency", lat_bad, 0);

        for (int i = 0; i < 260; i++) send_frame(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("err_sat", err_cnt, 8'hFF);

        busy = 1'b1;
        tick(2);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        tick(2);
        check_eq("midrst_regs", regs, 128'h0);
        check_eq("midrst_err_cnt", err_cnt, 8'h00);
        check_eq("midrst_tx_data", tx_data, 8'h00);
        check_eq("midrst_mem_addr", mem_addr, 16'h0000);
        rst = 1'b0;
        tick(2);
        send_byte(8'h10); send_byte(8'h02); send_byte(8'h33);
        tick(1);
        busy = 1'b0;
        tick(3);
        exp_regs = 128'h0;
        exp_regs[8*2 +: 8] = 8'h33;
        check_eq("postrst_regs", regs, exp_regs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
